wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order pipeline writeback path and a long-latency unit (mul/div result return).
- Pipeline writeback (already muxed: ALU / mem / pc+4, gated by reg-write) enters as one request.
- Long-latency results are buffered in a small FIFO and drained into idle write-port slots.
- Sits between WB stage, the mul/div unit and the register file. Exports a pending-register mask to the hazard unit.

---
 rtl/wb_port_arbiter.sv | 110 +++++++++++
 tb/tb_wb_port_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered long-latency results.
// Optional macro WB_ARB_STARVE_EN forces a FIFO slot after STARVE_MAX-1 denied cycles.
module wb_port_arbiter #(
   parameter int XLEN       = 32,
   parameter int REGW       = 5,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pipe_we,
   input  logic [REGW-1:0]         pipe_waddr,
   input  logic [XLEN-1:0]         pipe_wdata,
   output logic                    pipe_stall,
   input  logic                    lu_valid,
   input  logic [REGW-1:0]         lu_waddr,
   input  logic [XLEN-1:0]         lu_wdata,
   output logic                    lu_ready,
   output logic                    rf_we,
   output logic [REGW-1:0]         rf_waddr,
   output logic [XLEN-1:0]         rf_wdata,
   output logic [(2**REGW)-1:0]    pend_mask,
   output logic [$clog2(DEPTH):0]  fifo_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [REGW-1:0] waddr;
      logic [XLEN-1:0] wdata;
   } wb_req_t;

   wb_req_t              mem [DEPTH];
   logic [DEPTH-1:0]     vld, vld_nxt;
   logic [PW-1:0]        head, tail;
   logic [(2**REGW)-1:0] pend_nxt;
   logic                 preq, freq, enq, deq, override, grant_pipe;

   assign preq       = pipe_we && (pipe_waddr != '0);
   assign freq       = fifo_count != '0;
   assign lu_ready   = fifo_count < CW'(DEPTH);
   // x0 results complete the handshake but are dropped
   assign enq        = lu_valid && lu_ready && (lu_waddr != '0);
   assign deq        = freq && (!preq || override);
   assign grant_pipe = preq && !override;
   assign pipe_stall = override;

`ifdef WB_ARB_STARVE_EN
   localparam int SCW = $clog2(STARVE_MAX) + 1;
   logic [SCW-1:0] starve_cnt;

   assign override = preq && freq && (starve_cnt == SCW'(STARVE_MAX - 1));

   always_ff @(posedge clk) begin
      if (rst)
         starve_cnt <= '0;
      else if (!freq || deq)
         starve_cnt <= '0;
      else if (preq)
         starve_cnt <= starve_cnt + 1'b1;
   end
`else
   logic unused_starve;
   assign unused_starve = (STARVE_MAX > 0);
   assign override      = 1'b0;
`endif

   // pend_mask tracks the post-update FIFO contents so it lines up with fifo_count
   always_comb begin
      vld_nxt = vld;
      if (deq) vld_nxt[head] = 1'b0;
      if (enq) vld_nxt[tail] = 1'b1;
      pend_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_nxt[i])
            pend_nxt[(enq && tail == PW'(i)) ? lu_waddr : mem[i].waddr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) mem[tail] <= '{waddr: lu_waddr, wdata: lu_wdata};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head       <= '0;
         tail       <= '0;
         vld        <= '0;
         fifo_count <= '0;
         pend_mask  <= '0;
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
      end else begin
         if (enq) tail <= tail + 1'b1;
         if (deq) head <= head + 1'b1;
         vld        <= vld_nxt;
         pend_mask  <= pend_nxt;
         fifo_count <= fifo_count + CW'(enq) - CW'(deq);
         rf_we      <= grant_pipe || deq;
         if (grant_pipe) begin
            rf_waddr <= pipe_waddr;
            rf_wdata <= pipe_wdata;
         end else if (deq) begin
            rf_waddr <= mem[head].waddr;
            rf_wdata <= mem[head].wdata;
         end
      end
   end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector bench for wb_port_arbiter (default params: XLEN=32, REGW=5, DEPTH=2).
module tb_wb_port_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_we;
   logic [4:0]  pipe_waddr;
   logic [31:0] pipe_wdata;
   logic        pipe_stall;
   logic        lu_valid;
   logic [4:0]  lu_waddr;
   logic [31:0] lu_wdata;
   logic        lu_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] pend_mask;
   logic [1:0]  fifo_count;

   int n_vec = 0;
   int n_err = 0;

   wb_port_arbiter #(.XLEN(32), .REGW(5), .DEPTH(2), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata), .pipe_stall(pipe_stall),
      .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .lu_ready(lu_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .pend_mask(pend_mask), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   // inputs for one cycle; e_ready/e_stall checked before the edge, the rest after it
   typedef struct {
      string       name;
      logic        rst;
      logic        pwe;
      logic [4:0]  pa;
      logic [31:0] pd;
      logic        lv;
      logic [4:0]  la;
      logic [31:0] ld;
      logic        e_ready;
      logic        e_stall;
      logic        e_we;
      logic [4:0]  e_a;
      logic [31:0] e_d;
      logic [1:0]  e_cnt;
      logic [31:0] e_pend;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
      end
   endtask

   task automatic step(input vec_t v);
      @(negedge clk);
      rst = v.rst; pipe_we = v.pwe; pipe_waddr = v.pa; pipe_wdata = v.pd;
      lu_valid = v.lv; lu_waddr = v.la; lu_wdata = v.ld;
      #1;
      n_vec++;
      chk(v.name, "lu_ready", {31'd0, lu_ready}, {31'd0, v.e_ready});
      chk(v.name, "pipe_stall", {31'd0, pipe_stall}, {31'd0, v.e_stall});
      @(posedge clk);
      #1;
      chk(v.name, "rf_we", {31'd0, rf_we}, {31'd0, v.e_we});
      chk(v.name, "rf_waddr", {27'd0, rf_waddr}, {27'd0, v.e_a});
      chk(v.name, "rf_wdata", rf_wdata, v.e_d);
      chk(v.name, "fifo_count", {30'd0, fifo_count}, {30'd0, v.e_cnt});
      chk(v.name, "pend_mask", pend_mask, v.e_pend);
   endtask

   task automatic do_reset();
      rst = 1'b1; pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
      lu_valid = 0; lu_waddr = 0; lu_wdata = 0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      //        name      rst pwe pa  pd          lv la  ld         rdy stl we a   d           cnt pend
      vecs.push_back('{"rst",      1,0, 0, 32'h0,     0, 0, 32'h0,   1,0, 0, 0, 32'h0,    0, 32'h0});
      vecs.push_back('{"pipe5",    0,1, 5, 32'h1234,  0, 0, 32'h0,   1,0, 1, 5, 32'h1234, 0, 32'h0});
      vecs.push_back('{"idle_a",   0,0, 0, 32'h0,     0, 0, 32'h0,   1,0, 0, 5, 32'h1234, 0, 32'h0});
      vecs.push_back('{"lu7",      0,0, 0, 32'h0,     1, 7, 32'hAA,  1,0, 0, 5, 32'h1234, 1, 32'h80});
      vecs.push_back('{"drain7",   0,0, 0, 32'h0,     0, 0, 32'h0,   1,0, 1, 7, 32'hAA,   0, 32'h0});
      vecs.push_back('{"idle_b",   0,0, 0, 32'h0,     0, 0, 32'h0,   1,0, 0, 7, 32'hAA,   0, 32'h0});
      vecs.push_back('{"busy_p3",  0,1,10, 32'h100,   1, 3, 32'h1,   1,0, 1,10, 32'h100,  1, 32'h8});
      vecs.push_back('{"busy_p4",  0,1,11, 32'h101,   1, 4, 32'h2,   1,0, 1,11, 32'h101,  2, 32'h18});
      vecs.push_back('{"full_p5",  0,1,12, 32'h102,   1, 5, 32'h3,   0,0, 1,12, 32'h102,  2, 32'h18});
      vecs.push_back('{"drain3",   0,0, 0, 32'h0,     1, 5, 32'h3,   0,0, 1, 3, 32'h1,    1, 32'h10});
      vecs.push_back('{"enqdeq4",  0,0, 0, 32'h0,     1, 5, 32'h3,   1,0, 1, 4, 32'h2,    1, 32'h20});
      vecs.push_back('{"drain5",   0,0, 0, 32'h0,     0, 0, 32'h0,   1,0, 1, 5, 32'h3,    0, 32'h0});
      vecs.push_back('{"x0_lu9",   0,1, 0, 32'hDEAD,  1, 9, 32'h55,  1,0, 0, 5, 32'h3,    1, 32'h200});
      vecs.push_back('{"x0_drain", 0,1, 0, 32'hDEAD,  1, 0, 32'h77,  1,0, 1, 9, 32'h55,   0, 32'h0});
      vecs.push_back('{"lu_x0",    0,0, 0, 32'h0,     1, 0, 32'h77,  1,0, 0, 9, 32'h55,   0, 32'h0});
      vecs.push_back('{"fill20",   0,1, 1, 32'h11,    1,20, 32'h20,  1,0, 1, 1, 32'h11,   1, 32'h100000});
      vecs.push_back('{"fill21",   0,1, 2, 32'h22,    1,21, 32'h21,  1,0, 1, 2, 32'h22,   2, 32'h300000});
      vecs.push_back('{"rst_full", 1,1, 3, 32'h33,    1,22, 32'h22,  0,0, 0, 0, 32'h0,    0, 32'h0});
      vecs.push_back('{"post_rst", 0,0, 0, 32'h0,     0, 0, 32'h0,   1,0, 0, 0, 32'h0,    0, 32'h0});

      do_reset();
      foreach (vecs[i]) step(vecs[i]);

      // FIFO head against a continuously busy pipeline
      do_reset();
      step('{"s_rst",  1,0,0,32'h0,    0,0,32'h0,  1,0, 0,0,32'h0,    0,32'h0});
      step('{"s_lu2",  0,0,0,32'h0,    1,2,32'hB,  1,0, 0,0,32'h0,    1,32'h4});
`ifdef WB_ARB_STARVE_EN
      for (int k = 0; k < 3; k++)
         step('{$sformatf("s_pipe%0d", k), 0,1,1,32'h1111, 0,0,32'h0, 1,0, 1,1,32'h1111, 1,32'h4});
      step('{"s_force", 0,1,1,32'h1111, 0,0,32'h0, 1,1, 1,2,32'hB,    0,32'h0});
      step('{"s_resume",0,1,1,32'h1111, 0,0,32'h0, 1,0, 1,1,32'h1111, 0,32'h0});
`else
      for (int k = 0; k < 8; k++)
         step('{$sformatf("s_pipe%0d", k), 0,1,1,32'h1111, 0,0,32'h0, 1,0, 1,1,32'h1111, 1,32'h4});
      step('{"s_free", 0,0,0,32'h0, 0,0,32'h0, 1,0, 1,2,32'hB, 0,32'h0});
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
